// File: rtl/mult8x8_sequencer.sv
// 8x8 unsigned multiplier that time-shares one 4x4 array core over four
// nibble-pair steps, accumulating shifted partial products into 16 bits.

module Multiplier4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Array multiplier: one shifted row of a per set bit of b.
    always_comb begin
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                p = p + ({4'b0000, a} << i);
            end
        end
    end

endmodule

module mult8x8_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] P0   = 3'd1;
    localparam logic [2:0] P1   = 3'd2;
    localparam logic [2:0] P2   = 3'd3;
    localparam logic [2:0] P3   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]  state;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] acc;
    logic [3:0]  core_a;
    logic [3:0]  core_b;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;

    Multiplier4x4 u_core (
        .a (core_a),
        .b (core_b),
        .p (pp)
    );

    // NOTE: every output of a combinational block gets a default first so
    // unlisted states cannot infer a latch.
    always_comb begin
        core_a     = '0;
        core_b     = '0;
        pp_shifted = '0;
        case (state)
            P0: begin
                core_a     = ra[3:0];
                core_b     = rb[3:0];
                pp_shifted = {8'h00, pp};
            end
            P1: begin
                core_a     = ra[7:4];
                core_b     = rb[3:0];
                pp_shifted = {4'h0, pp, 4'h0};
            end
            P2: begin
                core_a     = ra[3:0];
                core_b     = rb[7:4];
                pp_shifted = {4'h0, pp, 4'h0};
            end
            P3: begin
                core_a     = ra[7:4];
                core_b     = rb[7:4];
                pp_shifted = {pp, 8'h00};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ra      <= '0;
            rb      <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        acc   <= '0;
                        state <= P0;
                    end else begin
                        state <= IDLE;
                    end
                end
                P0, P1, P2: begin
                    acc   <= acc + pp_shifted;
                    state <= state + 3'd1;
                end
                P3: begin
                    product <= acc + pp_shifted;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state only; no input reaches them combinationally.
    assign busy = (state == P0) || (state == P1) || (state == P2) || (state == P3);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mult8x8_sequencer.sv
// Self-checking bench for mult8x8_sequencer: reference products come from
// plain a*b arithmetic, with latency and handshake expectations per cycle.

module tb_mult8x8_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int passed;
    int total;
    logic prev_done;

    mult8x8_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Cycle invariants: busy/done exclusive, done never on two cycles in a row.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (busy && done) $display("FAIL busy_done_overlap busy=%b done=%b required not both 1", busy, done);
            else passed++;
            total++;
            if (prev_done && done) $display("FAIL done_twice done=%b on consecutive cycles required 0", done);
            else passed++;
        end
        prev_done = rst ? 1'b0 : done;
    end

    // One operation with a one-cycle start; checks busy window, done edge and product.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input string name);
        logic [15:0] exp;
        exp = ref_mul(ta, tb_v);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL %s_busy_cycle%0d busy=%b done=%b required busy=1 done=0", name, i, busy, done);
            else passed++;
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s_done done=%b busy=%b required done=1 busy=0", name, done, busy);
        else passed++;
        total++;
        if (product !== exp)
            $display("FAIL %s_product got=%h required=%h", name, product, exp);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || product !== exp)
            $display("FAIL %s_after done=%b product=%h required done=0 product=%h", name, done, product, exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #3;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000)
            $display("FAIL reset_state busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(8'hFF, 8'hFF, "ff_ff");
        run_op(8'h12, 8'h34, "h12_h34");
        run_op(8'h00, 8'hA7, "zero_a");
        run_op(8'hA7, 8'h00, "zero_b");
        run_op(8'h01, 8'hFF, "one_ff");
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [15:0] seen;
        dones = 0;
        seen = '0;
        @(negedge clk);
        a = 8'h0F;
        b = 8'h10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                seen = product;
            end
            @(negedge clk);
        end
        total++;
        if (dones != 1) $display("FAIL ignore_done_count got=%0d required=1", dones);
        else passed++;
        total++;
        if (seen !== 16'h00F0) $display("FAIL ignore_product got=%h required=00f0", seen);
        else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a = 8'h03;
        b = 8'h05;
        start = 1'b1;
        @(negedge clk);
        a = 8'h07;
        b = 8'h09;
        for (int j = 0; j <= 10; j++) begin
            total++;
            if (done !== (j == 4 || j == 9))
                $display("FAIL b2b_done_j%0d got=%b required=%b", j, done, (j == 4 || j == 9));
            else passed++;
            if (j == 4) begin
                total++;
                if (product !== ref_mul(8'h03, 8'h05))
                    $display("FAIL b2b_first_product got=%h required=%h", product, ref_mul(8'h03, 8'h05));
                else passed++;
            end
            if (j == 9) begin
                total++;
                if (product !== ref_mul(8'h07, 8'h09))
                    $display("FAIL b2b_second_product got=%h required=%h", product, ref_mul(8'h07, 8'h09));
                else passed++;
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        int dones;
        dones = 0;
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000)
            $display("FAIL async_reset busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        total++;
        if (dones != 0) $display("FAIL async_no_resume active_cycles=%0d required=0", dones);
        else passed++;
        run_op(8'h02, 8'h03, "post_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            run_op(8'($urandom), 8'($urandom), "random");
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        prev_done = 1'b0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
